// File: rtl/div_share_ctrl.sv
// rtl/div_share_ctrl.sv - shares one iterative divider core between two EX lanes
module div_share_ctrl #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      div_en_i,
    input  logic [1:0]      div_sign_i,
    input  logic [2*DW-1:0] dividend_i,
    input  logic [2*DW-1:0] divisor_i,
    input  logic [1:0]      lane_fire_i,
    input  logic            excep_flush_i,
    output logic [2*DW-1:0] quotient_o,
    output logic [2*DW-1:0] remainder_o,
    output logic [1:0]      div_complete_o,
    output logic            core_start_o,
    output logic            core_sign_o,
    output logic [DW-1:0]   core_dividend_o,
    output logic [DW-1:0]   core_divisor_o,
    output logic            core_cancel_o,
    input  logic            core_done_i,
    input  logic [DW-1:0]   core_quotient_i,
    input  logic [DW-1:0]   core_remainder_i,
    output logic            busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY} state_t;

    state_t        state_q;
    logic          owner_q;
    logic          sign_q;
    logic [DW-1:0] dividend_q;
    logic [DW-1:0] divisor_q;
    logic          core_start_q;
    logic          core_cancel_q;
    logic [1:0]    res_valid_q;
    logic [1:0]    res_valid_d;
    logic [DW-1:0] quot_q [2];
    logic [DW-1:0] rem_q  [2];

    logic [1:0] eligible;
    logic       grant;
    logic       cancel_cond;
    logic       done_ok;
    logic [1:0] res_set;
    logic [1:0] res_clr;

    // A lane holding a finished result is not eligible, so lane0 can never starve lane1.
    always_comb begin
        eligible    = div_en_i & ~res_valid_q & {2{~excep_flush_i}};
        grant       = ~eligible[0];
        cancel_cond = excep_flush_i | ~div_en_i[owner_q];
        done_ok     = (state_q == S_BUSY) & core_done_i & ~cancel_cond;
        res_set     = done_ok ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        res_clr     = lane_fire_i | ~div_en_i | {2{excep_flush_i}};
        res_valid_d = (res_valid_q | res_set) & ~res_clr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            owner_q       <= 1'b0;
            sign_q        <= 1'b0;
            dividend_q    <= '0;
            divisor_q     <= '0;
            core_start_q  <= 1'b0;
            core_cancel_q <= 1'b0;
            res_valid_q   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                quot_q[i] <= '0;
                rem_q[i]  <= '0;
            end
        end else begin
            core_start_q  <= 1'b0;
            core_cancel_q <= 1'b0;
            res_valid_q   <= res_valid_d;
            for (int i = 0; i < 2; i++) begin
                if (res_set[i]) begin
                    quot_q[i] <= core_quotient_i;
                    rem_q[i]  <= core_remainder_i;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (|eligible) begin
                        owner_q      <= grant;
                        sign_q       <= div_sign_i[grant];
                        dividend_q   <= grant ? dividend_i[DW +: DW] : dividend_i[0 +: DW];
                        divisor_q    <= grant ? divisor_i[DW +: DW]  : divisor_i[0 +: DW];
                        core_start_q <= 1'b1;
                        state_q      <= S_START;
                    end
                end
                S_START: begin
                    if (cancel_cond) begin
                        core_cancel_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // A core that finishes in the cancel cycle is already idle; no abort needed.
                    if (cancel_cond) begin
                        core_cancel_q <= ~core_done_i;
                        state_q       <= S_IDLE;
                    end else if (core_done_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign quotient_o      = {quot_q[1], quot_q[0]};
    assign remainder_o     = {rem_q[1], rem_q[0]};
    assign div_complete_o  = res_valid_q;
    assign core_start_o    = core_start_q;
    assign core_cancel_o   = core_cancel_q;
    assign core_sign_o     = sign_q;
    assign core_dividend_o = dividend_q;
    assign core_divisor_o  = divisor_q;
    assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_share_ctrl.sv
// tb/tb_div_share_ctrl.sv - randomized self-checking bench for div_share_ctrl
module tb_div_share_ctrl;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      div_en_i, div_sign_i, lane_fire_i;
    logic [2*DW-1:0] dividend_i, divisor_i;
    logic            excep_flush_i;
    logic [2*DW-1:0] quotient_o, remainder_o;
    logic [1:0]      div_complete_o;
    logic            core_start_o, core_sign_o, core_cancel_o, core_done_i, busy_o;
    logic [DW-1:0]   core_dividend_o, core_divisor_o, core_quotient_i, core_remainder_i;

    div_share_ctrl #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .div_en_i(div_en_i), .div_sign_i(div_sign_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .lane_fire_i(lane_fire_i),
        .excep_flush_i(excep_flush_i), .quotient_o(quotient_o), .remainder_o(remainder_o),
        .div_complete_o(div_complete_o), .core_start_o(core_start_o), .core_sign_o(core_sign_o),
        .core_dividend_o(core_dividend_o), .core_divisor_o(core_divisor_o),
        .core_cancel_o(core_cancel_o), .core_done_i(core_done_i),
        .core_quotient_i(core_quotient_i), .core_remainder_i(core_remainder_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_div(input logic s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    output logic [DW-1:0] q, output logic [DW-1:0] r);
        longint sa, sb;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = DW'(sa / sb);
            r  = DW'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Behavioural divider core: fixed latency 'lat' from start to done, abortable.
    int            lat = 4;
    int            cnt = 0;
    logic          mdone = 1'b0;
    logic          force_done = 1'b0;
    logic [DW-1:0] mq = '0, mr = '0;
    int            n_starts = 0, n_cancels = 0;

    assign core_done_i      = mdone | force_done;
    assign core_quotient_i  = mq;
    assign core_remainder_i = mr;

    always @(posedge clk) begin
        logic [DW-1:0] q, r;
        if (rst || core_cancel_o) begin
            cnt   <= 0;
            mdone <= 1'b0;
        end else if (core_start_o) begin
            ref_div(core_sign_o, core_dividend_o, core_divisor_o, q, r);
            mq    <= q;
            mr    <= r;
            cnt   <= lat - 1;
            mdone <= (lat == 1);
        end else if (cnt > 0) begin
            cnt   <= cnt - 1;
            mdone <= (cnt == 1);
        end else begin
            mdone <= 1'b0;
        end
        if (!rst && core_start_o)  n_starts  <= n_starts + 1;
        if (!rst && core_cancel_o) n_cancels <= n_cancels + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits from the request cycle (cycle 0) for each requested lane to complete.
    task automatic wait_done(input logic [1:0] mask, input int budget,
                             output int s, output int c0, output int c1, output logic hold0);
        s = -1; c0 = -1; c1 = -1; hold0 = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            step();
            if (s < 0 && core_start_o) s = k;
            if (mask[0] && c0 < 0 && div_complete_o[0]) c0 = k;
            if (mask[1] && c1 < 0 && div_complete_o[1]) begin
                c1    = k;
                hold0 = div_complete_o[0];
            end
            if ((!mask[0] || c0 >= 0) && (!mask[1] || c1 >= 0)) break;
        end
    endtask

    task automatic release_lanes(input logic [1:0] mask);
        lane_fire_i = mask;
        step();
        lane_fire_i = 2'b00;
        div_en_i    = 2'b00;
        chk("fire_clears", div_complete_o & mask, 2'b00);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            s, c0, c1, ns, nc;
        logic          h0;
        logic [DW-1:0] a0, b0, a1, b1, eq0, er0, eq1, er1;
        logic [1:0]    mask;
        logic [1:0]    sg;

        rst = 1'b1; div_en_i = 0; div_sign_i = 0; lane_fire_i = 0; excep_flush_i = 0;
        dividend_i = 0; divisor_i = 0;
        step(); step();
        chk("rst_busy", busy_o, 0);
        chk("rst_complete", div_complete_o, 0);
        chk("rst_core_out", {core_start_o, core_cancel_o, core_sign_o, core_dividend_o}, 0);
        chk("rst_results", quotient_o | remainder_o, 0);
        rst = 1'b0;
        step();

        // Lane0 only, 100/7 unsigned, latency 33.
        lat = 33;
        div_en_i = 2'b01; div_sign_i = 2'b00;
        dividend_i = {32'd0, 32'd100}; divisor_i = {32'd0, 32'd7};
        wait_done(2'b01, 60, s, c0, c1, h0);
        chk("t1_start_cycle", s, 1);
        chk("t1_complete_cycle", c0, 35);
        chk("t1_quot", quotient_o[31:0], 14);
        chk("t1_rem", remainder_o[31:0], 2);
        step(); step(); step();
        chk("t1_held", {div_complete_o[0], quotient_o[31:0]}, {1'b1, 32'd14});
        release_lanes(2'b01);

        // Both lanes at once: lane0 signed -100/7, lane1 unsigned 0xFFFFFFFF/16.
        lat = 5;
        div_en_i = 2'b11; div_sign_i = 2'b01;
        dividend_i = {32'hFFFF_FFFF, 32'hFFFF_FF9C}; divisor_i = {32'd16, 32'd7};
        wait_done(2'b11, 60, s, c0, c1, h0);
        chk("t2_lane0_cycle", c0, 2 + 5);
        chk("t2_lane1_cycle", c1, 4 + 2 * 5);
        chk("t2_lane0_held", h0, 1);
        chk("t2_q", quotient_o, {32'h0FFF_FFFF, 32'hFFFF_FFF2});
        chk("t2_r", remainder_o, {32'h0000_000F, 32'hFFFF_FFFE});
        release_lanes(2'b11);

        // Stalled lane0 is never restarted; lane1 is served meanwhile.
        lat = 8;
        div_en_i = 2'b01; div_sign_i = 2'b00;
        dividend_i = {32'd1000, 32'd55}; divisor_i = {32'd9, 32'd5};
        wait_done(2'b01, 40, s, c0, c1, h0);
        ns = n_starts;
        for (int k = 0; k < 10; k++) step();
        chk("t3_no_restart", n_starts, ns);
        chk("t3_stable", {div_complete_o[0], quotient_o[31:0], remainder_o[31:0]}, {1'b1, 32'd11, 32'd0});
        div_en_i = 2'b11;
        wait_done(2'b10, 40, s, c0, c1, h0);
        chk("t3_lane1_cycle", c1, 2 + 8);
        chk("t3_one_start", n_starts, ns + 1);
        chk("t3_lane1_res", {quotient_o[63:32], remainder_o[63:32]}, {32'd111, 32'd1});
        chk("t3_lane0_held", h0, 1);
        release_lanes(2'b11);

        // Flush during BUSY aborts, then a fresh request runs normally.
        lat = 20; nc = n_cancels;
        div_en_i = 2'b01; dividend_i = {32'd0, 32'd77}; divisor_i = {32'd0, 32'd10};
        for (int k = 0; k < 5; k++) step();
        chk("t4_busy", busy_o, 1);
        excep_flush_i = 1'b1; div_en_i = 2'b00;
        step();
        excep_flush_i = 1'b0;
        chk("t4_cancel_pulse", {core_cancel_o, busy_o}, 2'b10);
        step();
        chk("t4_cancel_once", {core_cancel_o, 32'(n_cancels)}, {1'b0, 32'(nc + 1)});
        for (int k = 0; k < 25; k++) step();
        chk("t4_no_complete", div_complete_o, 0);
        lat = 4;
        div_en_i = 2'b01;
        wait_done(2'b01, 20, s, c0, c1, h0);
        chk("t4_restart_cycle", c0, 6);
        chk("t4_restart_res", {quotient_o[31:0], remainder_o[31:0]}, {32'd7, 32'd7});
        release_lanes(2'b01);

        // Request withdrawn in the very cycle the core finishes.
        lat = 10; nc = n_cancels;
        div_en_i = 2'b01; dividend_i = {32'd0, 32'd500}; divisor_i = {32'd0, 32'd3};
        for (int k = 0; k < 11; k++) step();
        div_en_i = 2'b00;
        step();
        chk("t5_no_cancel", {core_cancel_o, busy_o}, 2'b00);
        step();
        chk("t5_discarded", {div_complete_o, 32'(n_cancels)}, {2'b00, 32'(nc)});

        // Reset mid-BUSY with a stray done right after.
        lat = 10;
        div_en_i = 2'b01; dividend_i = {32'd0, 32'd90}; divisor_i = {32'd0, 32'd4};
        for (int k = 0; k < 5; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0; div_en_i = 2'b00; force_done = 1'b1;
        chk("t6_reset_outs", {busy_o, core_start_o, core_cancel_o, div_complete_o, quotient_o[31:0]}, 0);
        step();
        force_done = 1'b0;
        chk("t6_done_ignored", {busy_o, div_complete_o, quotient_o, remainder_o}, 0);
        step();

        // Randomized transactions against the arithmetic reference.
        for (int it = 0; it < 12; it++) begin
            lat  = int'($urandom_range(1, 12));
            mask = 2'($urandom_range(1, 3));
            sg   = 2'($urandom_range(0, 3));
            a0 = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 1000);
            a1 = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 1000);
            b0 = ($urandom_range(0, 7) == 0) ? 0 : (($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(1, 50));
            b1 = ($urandom_range(0, 7) == 0) ? 0 : (($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(1, 50));
            ref_div(sg[0], a0, b0, eq0, er0);
            ref_div(sg[1], a1, b1, eq1, er1);
            div_en_i = mask; div_sign_i = sg;
            dividend_i = {a1, a0}; divisor_i = {b1, b0};
            wait_done(mask, 60, s, c0, c1, h0);
            if (mask[0]) begin
                chk("rnd_lane0_cycle", c0, 2 + lat);
                chk("rnd_lane0_res", {quotient_o[31:0], remainder_o[31:0]}, {eq0, er0});
            end
            if (mask[1]) begin
                chk("rnd_lane1_cycle", c1, mask[0] ? 4 + 2 * lat : 2 + lat);
                chk("rnd_lane1_res", {quotient_o[63:32], remainder_o[63:32]}, {eq1, er1});
            end
            if (mask == 2'b11) chk("rnd_lane0_held", h0, 1);
            release_lanes(mask);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
